// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 packet framer.
//   BYTE_W  : width of one received byte
//   state_t : framer FSM states (2-bit encoding; 2'b11 is unused and recovers
//             to S_SEARCH)
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'b00,
        S_COLLECT = 2'b01,
        S_DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/ps2_sat_counter.sv
// ----------------------------------------------------------------------------
// ps2_sat_counter
// Saturating up-counter. It holds at all-ones instead of wrapping. Clear has
// priority over increment.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (value -> 0)
//   inc_i    in  count one event this cycle
//   clear_i  in  synchronous clear
//   value_o  out current count
// ----------------------------------------------------------------------------
module ps2_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != {W{1'b1}})) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/ps2_packet_framer.sv
// ----------------------------------------------------------------------------
// ps2_packet_framer
// Scans a received byte stream for a sync byte (in_byte[SYNC_BIT] set). It
// assembles PKT_BYTES-byte packets and presents each finished packet on
// out_bytes together with a 1-cycle done pulse. An optional inter-byte
// timeout aborts a stalled packet. A saturating counter tallies every
// discarded byte and every aborted packet.
//
// Handshake: the input has no backpressure. A byte is consumed on every
// rising edge where in_valid=1. done is high for exactly one cycle, and
// out_bytes is valid from that cycle until the next completed packet.
//
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   in_byte valid this cycle
//   in_byte    in   received byte
//   done       out  1-cycle pulse, out_bytes holds a complete packet
//   out_bytes  out  last packet, first (sync) byte in the MSBs
//   busy       out  high while a packet is being collected
//   drop_cnt   out  saturating count of dropped bytes + aborted packets
// ----------------------------------------------------------------------------
module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int PKT_BYTES = 3,
    parameter int SYNC_BIT  = 3,
    parameter int TIMEOUT   = 0,
    parameter int DROP_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [BYTE_W-1:0]           in_byte,
    output logic                        done,
    output logic [BYTE_W*PKT_BYTES-1:0] out_bytes,
    output logic                        busy,
    output logic [DROP_W-1:0]           drop_cnt
);

    if (PKT_BYTES < 2 || PKT_BYTES > 8) begin : g_bad_pkt_bytes
        $fatal(1, "ps2_packet_framer: PKT_BYTES must be 2..8");
    end
    if (SYNC_BIT < 0 || SYNC_BIT > 7) begin : g_bad_sync_bit
        $fatal(1, "ps2_packet_framer: SYNC_BIT must be 0..7");
    end

    localparam int PKT_W = BYTE_W * PKT_BYTES;
    localparam int IDX_W = $clog2(PKT_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

    // The idle counter runs 0..TIMEOUT-1. An idle cycle that finds it at
    // TIMEOUT-1 is the TIMEOUT-th idle cycle, so that cycle aborts.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PKT_W-1:0] asm_q, asm_d;
    logic [PKT_W-1:0] out_q, out_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             drop_inc;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        out_d    = out_q;
        to_d     = to_q;
        drop_inc = 1'b0;
        case (state_q)
            // S_DONE accepts bytes exactly like S_SEARCH, so a sync byte
            // arriving in the done cycle starts the next packet with no gap.
            S_SEARCH, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_SEARCH;
                end
                if (in_valid) begin
                    if (in_byte[SYNC_BIT]) begin
                        asm_d[PKT_W-1 -: BYTE_W] = in_byte;
                        idx_d   = IDX_W'(1);
                        to_d    = '0;
                        state_d = S_COLLECT;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    asm_d[(PKT_BYTES - 1 - int'(idx_q)) * BYTE_W +: BYTE_W] = in_byte;
                    to_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // Capture the buffer including the byte that completes it.
                        out_d   = asm_d;
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (TIMEOUT > 0) begin
                    if (to_q == TO_LAST) begin
                        idx_d    = '0;
                        to_d     = '0;
                        drop_inc = 1'b1;
                        state_d  = S_SEARCH;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                to_d    = '0;
                state_d = S_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SEARCH;
            idx_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            to_q    <= to_d;
        end
    end

    ps2_sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .inc_i   (drop_inc),
        .clear_i (1'b0),
        .value_o (drop_cnt)
    );

    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_COLLECT);
    assign out_bytes = out_q;

endmodule

// File: tb/tb_ps2_packet_framer.sv
// ----------------------------------------------------------------------------
// tb_ps2_packet_framer
// Three framer instances share one clock and one reset:
//   k=0 : defaults (3 bytes, sync bit 3, no timeout)
//   k=1 : TIMEOUT=4
//   k=2 : PKT_BYTES=4, SYNC_BIT=0
// A packet-level model predicts every output on every cycle. Directed
// sequences then pin the model with hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_ps2_packet_framer;

  localparam int NB  [3] = '{3, 3, 4};
  localparam int SB  [3] = '{3, 3, 0};
  localparam int TOV [3] = '{0, 4, 0};
  localparam int DROP_MAX = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       in_valid [3];
  logic [7:0] in_byte  [3];

  logic        u0_done, u0_busy, u1_done, u1_busy, u2_done, u2_busy;
  logic [23:0] u0_out, u1_out;
  logic [31:0] u2_out;
  logic [7:0]  u0_drop, u1_drop, u2_drop;

  ps2_packet_framer u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_byte(in_byte[0]),
    .done(u0_done), .out_bytes(u0_out), .busy(u0_busy), .drop_cnt(u0_drop));

  ps2_packet_framer #(.TIMEOUT(4)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_byte(in_byte[1]),
    .done(u1_done), .out_bytes(u1_out), .busy(u1_busy), .drop_cnt(u1_drop));

  ps2_packet_framer #(.PKT_BYTES(4), .SYNC_BIT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_byte(in_byte[2]),
    .done(u2_done), .out_bytes(u2_out), .busy(u2_busy), .drop_cnt(u2_drop));

  logic        dut_done [3];
  logic        dut_busy [3];
  logic [63:0] dut_out  [3];
  logic [63:0] dut_drop [3];
  assign dut_done[0] = u0_done;  assign dut_busy[0] = u0_busy;
  assign dut_done[1] = u1_done;  assign dut_busy[1] = u1_busy;
  assign dut_done[2] = u2_done;  assign dut_busy[2] = u2_busy;
  assign dut_out[0]  = 64'(u0_out);  assign dut_drop[0] = 64'(u0_drop);
  assign dut_out[1]  = 64'(u1_out);  assign dut_drop[1] = 64'(u1_drop);
  assign dut_out[2]  = 64'(u2_out);  assign dut_drop[2] = 64'(u2_drop);

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  int cyc = 0;
  logic [63:0] exp_q [$];   // cycle numbers of done pulses seen on k=0

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  // The model works on packets, not FSM states. m_len is the number of
  // bytes held for the packet in progress, and 0 means hunting for sync.
  int          m_len  [3];
  logic [7:0]  m_pkt  [3][8];
  int          m_idle [3];
  int          m_drop [3];
  logic        m_done [3];
  logic [63:0] m_out  [3];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_len[k] = 0; m_idle[k] = 0; m_drop[k] = 0; m_done[k] = 1'b0; m_out[k] = '0;
    end
  endtask

  task automatic model_step();
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      b = in_byte[k];
      m_done[k] = 1'b0;
      if (m_len[k] > 0) begin
        if (in_valid[k]) begin
          m_pkt[k][m_len[k]] = b;
          m_len[k]++;
          m_idle[k] = 0;
          if (m_len[k] == NB[k]) begin
            m_out[k] = '0;
            for (int i = 0; i < NB[k]; i++) m_out[k] = (m_out[k] << 8) | 64'(m_pkt[k][i]);
            m_done[k] = 1'b1;
            m_len[k] = 0;
          end
        end else if (TOV[k] > 0) begin
          m_idle[k]++;
          if (m_idle[k] == TOV[k]) begin
            m_len[k] = 0;
            if (m_drop[k] < DROP_MAX) m_drop[k]++;
          end
        end
      end else if (in_valid[k]) begin
        if (b[SB[k]]) begin
          m_pkt[k][0] = b;
          m_len[k] = 1;
          m_idle[k] = 0;
        end else if (m_drop[k] < DROP_MAX) begin
          m_drop[k]++;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          check($sformatf("cmp_done[%0d]", k), 64'(dut_done[k]), 64'(m_done[k]));
          check($sformatf("cmp_busy[%0d]", k), 64'(dut_busy[k]), 64'(m_len[k] > 0));
          check($sformatf("cmp_out[%0d]", k), dut_out[k], m_out[k]);
          check($sformatf("cmp_drop[%0d]", k), dut_drop[k], 64'(m_drop[k]));
        end
        if (dut_done[0] === 1'b1) exp_q.push_back(64'(cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic v, input logic [7:0] b);
    @(negedge clk);
    #1;
    in_valid[k] = v;
    in_byte[k]  = b;
  endtask

  task automatic send(input int k, input logic [7:0] b);
    drive(k, 1'b1, b);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'b0, 8'h00);
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_byte[k]  = 8'h00;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out", 64'(u0_out), 64'h0);
    check("rst_done", 64'(u0_done), 64'h0);
    check("rst_busy", 64'(u0_busy), 64'h0);
    check("rst_drop", 64'(u2_drop), 64'h0);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // 1: basic packet, done one cycle after the last byte
    send(0, 8'h08); send(0, 8'hAA); send(0, 8'h55);
    idle(0, 1);
    check("t1_done", 64'(u0_done), 64'h1);
    check("t1_out", 64'(u0_out), 64'h08AA55);
    check("t1_drop", 64'(u0_drop), 64'h0);
    idle(0, 1);
    check("t1_done_off", 64'(u0_done), 64'h0);

    // 2: non-sync bytes are dropped
    send(0, 8'h00); send(0, 8'h00);
    send(0, 8'h2C); send(0, 8'h11); send(0, 8'h22);
    idle(0, 1);
    check("t2_done", 64'(u0_done), 64'h1);
    check("t2_out", 64'(u0_out), 64'h2C1122);
    check("t2_drop", 64'(u0_drop), 64'h2);
    idle(0, 2);

    // 3: back-to-back packets
    exp_q.delete();
    send(0, 8'h08); send(0, 8'h01); send(0, 8'h02); send(0, 8'h18);
    check("t3_done1", 64'(u0_done), 64'h1);
    check("t3_out1", 64'(u0_out), 64'h080102);
    send(0, 8'h03); send(0, 8'h04);
    idle(0, 1);
    check("t3_done2", 64'(u0_done), 64'h1);
    check("t3_out2", 64'(u0_out), 64'h180304);
    idle(0, 2);
    check("t3_npulse", 64'(exp_q.size()), 64'h2);
    if (exp_q.size() == 2) check("t3_gap", exp_q[1] - exp_q[0], 64'h3);

    // 4: timeout abort after 4 idle cycles, then 3-cycle gaps complete
    send(1, 8'h08); send(1, 8'h01);
    idle(1, 3);
    check("t4_busy_mid", 64'(u1_busy), 64'h1);
    idle(1, 2);
    check("t4_busy", 64'(u1_busy), 64'h0);
    check("t4_drop", 64'(u1_drop), 64'h1);
    check("t4_done", 64'(u1_done), 64'h0);
    send(1, 8'h08); idle(1, 3);
    send(1, 8'h11); idle(1, 3);
    send(1, 8'h22);
    idle(1, 1);
    check("t4_done2", 64'(u1_done), 64'h1);
    check("t4_out2", 64'(u1_out), 64'h081122);
    check("t4_drop2", 64'(u1_drop), 64'h1);
    idle(1, 2);

    // 5: reset in the middle of a packet
    send(0, 8'h08); send(0, 8'h01);
    idle(0, 1);
    check("t5_busy_pre", 64'(u0_busy), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_out", 64'(u0_out), 64'h0);
    check("t5_rst_busy", 64'(u0_busy), 64'h0);
    check("t5_rst_drop", 64'(u0_drop), 64'h0);
    check("t5_rst_drop1", 64'(u1_drop), 64'h0);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    send(0, 8'h0C); send(0, 8'h33); send(0, 8'h44);
    idle(0, 1);
    check("t5_done", 64'(u0_done), 64'h1);
    check("t5_out", 64'(u0_out), 64'h0C3344);
    check("t5_drop", 64'(u0_drop), 64'h0);
    idle(0, 2);

    // 6: drop counter saturation, 4-byte packet, sync on bit 0
    for (int i = 0; i < 300; i++) send(2, 8'h00);
    idle(2, 1);
    check("t6_drop_sat", 64'(u2_drop), 64'd255);
    send(2, 8'h01); send(2, 8'h02); send(2, 8'h03); send(2, 8'h04);
    idle(2, 1);
    check("t6_done", 64'(u2_done), 64'h1);
    check("t6_out", 64'(u2_out), 64'h01020304);
    check("t6_drop", 64'(u2_drop), 64'd255);
    idle(2, 3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
